// File: rtl/width_mode_ctrl.sv
// Sequences the 8-to-n deserializer: gates bytes with enb and owns the width select dataS.
// Width changes take effect only at word boundaries; wordValid/modeAck are registered one-cycle pulses.
module width_mode_ctrl #(
    parameter int          CNT_W      = 16,
    parameter logic [1:0]  RESET_MODE = 2'b00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             byteValid,
    input  logic [1:0]       modeReq,
    input  logic             modeReqValid,
    output logic             modeAck,
    output logic [1:0]       dataS,
    output logic             enb,
    output logic [1:0]       bytePhase,
    output logic             wordValid,
    output logic [CNT_W-1:0] wordCount,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         data_s_q, data_s_d;
    logic [1:0]         phase_q, phase_d;
    logic               word_vld_q, word_vld_d;
    logic               mode_ack_q, mode_ack_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic               pending_q, pending_d;
    logic [1:0]         pend_mode_q, pend_mode_d;
    logic               stop_pend_q, stop_pend_d;

    logic [1:0]         last_phase;
    logic               last_byte;
    logic               accept;
    logic               boundary;

    always_comb begin
        case (data_s_q)
            2'b01:   last_phase = 2'd1;
            2'b10:   last_phase = 2'd3;
            default: last_phase = 2'd0;
        endcase
    end

    assign last_byte = (phase_q == last_phase);
    assign accept    = (state_q == ST_RUN) && byteValid;
    // A word boundary is either the final byte of a word or an empty phase with no byte arriving.
    assign boundary  = accept ? last_byte : (phase_q == 2'd0);

    always_comb begin
        state_d     = state_q;
        data_s_d    = data_s_q;
        phase_d     = phase_q;
        word_vld_d  = 1'b0;
        mode_ack_d  = 1'b0;
        word_cnt_d  = word_cnt_q;
        pending_d   = pending_q;
        pend_mode_d = pend_mode_q;
        stop_pend_d = stop_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (modeReqValid) begin
                    data_s_d   = modeReq;
                    mode_ack_d = 1'b1;
                    pending_d  = 1'b0;
                end
                if (start && !stop) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (accept) begin
                    if (last_byte) begin
                        phase_d    = 2'd0;
                        word_vld_d = 1'b1;
                        word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
                if (modeReqValid) begin
                    if (!pending_q && (modeReq == data_s_q)) begin
                        mode_ack_d = 1'b1;
                    end else begin
                        pend_mode_d = modeReq;
                        pending_d   = 1'b1;
                    end
                end
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (boundary) begin
                    if (pending_d) begin
                        state_d = ST_SWITCH;
                    end else if (stop_pend_q) begin
                        state_d     = ST_IDLE;
                        stop_pend_d = 1'b0;
                    end
                end
            end

            ST_SWITCH: begin
                data_s_d   = pend_mode_q;
                phase_d    = 2'd0;
                mode_ack_d = 1'b1;
                pending_d  = 1'b0;
                if (modeReqValid) begin
                    pend_mode_d = modeReq;
                    pending_d   = 1'b1;
                end
                // A stop arriving on the exit cycle is kept so the next boundary in RUN honours it.
                if (stop_pend_q) begin
                    state_d     = ST_IDLE;
                    stop_pend_d = 1'b0;
                end else begin
                    state_d     = ST_RUN;
                    stop_pend_d = stop;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            data_s_q    <= RESET_MODE;
            phase_q     <= 2'd0;
            word_vld_q  <= 1'b0;
            mode_ack_q  <= 1'b0;
            word_cnt_q  <= '0;
            pending_q   <= 1'b0;
            pend_mode_q <= 2'b00;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_s_q    <= data_s_d;
            phase_q     <= phase_d;
            word_vld_q  <= word_vld_d;
            mode_ack_q  <= mode_ack_d;
            word_cnt_q  <= word_cnt_d;
            pending_q   <= pending_d;
            pend_mode_q <= pend_mode_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    assign enb       = accept;
    assign dataS     = data_s_q;
    assign bytePhase = phase_q;
    assign wordValid = word_vld_q;
    assign modeAck   = mode_ack_q;
    assign wordCount = word_cnt_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
